// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-master memory arbiter: lock FSM state
// encoding, master index constants and the lock counter helpers.
package mem_arbiter2_pkg;

    // Lock FSM states: free arbitration, or the bus held by one master.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    // Master indices, also used as the encoding of last_grant / rd_owner.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // The lock counter is 8 bits wide and saturates instead of wrapping.
    localparam int CNT_WIDTH = 8;

    typedef logic [CNT_WIDTH-1:0] lock_cnt_t;

    // Increment that sticks at all-ones so a long lock never wraps to zero.
    function automatic lock_cnt_t sat_inc(input lock_cnt_t value);
        lock_cnt_t result;
        if (value == '1) begin
            result = value;
        end else begin
            result = value + lock_cnt_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: round-robin or fixed priority between two requests,
// with a one-shot override that hands the grant to a chosen master.
module arb_rr2
    import mem_arbiter2_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic req0,
    input  logic req1,
    input  logic force_en,
    input  logic force_sel,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;
    logic pick;
    logic forced_req;

    // Choose a winner: the override first, then the tie rule, then whoever asks.
    always_comb begin
        pick       = M0;
        forced_req = (force_sel == M1) ? req1 : req0;
        if (force_en && forced_req) begin
            pick = force_sel;
        end else if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
                pick = M0;
            end else begin
                pick = ~last_grant;
            end
        end else if (req1) begin
            pick = M1;
        end else begin
            pick = M0;
        end
        gnt0 = req0 && (pick == M0);
        gnt1 = req1 && (pick == M1);
    end

    // Remember who was served last; starting at m1 lets m0 win the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= M1;
        end else if (gnt0 || gnt1) begin
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Shares one single-port synchronous RAM between two valid/ready masters,
// with round-robin or fixed-priority arbitration and a bounded bus lock
// for atomic read-modify-write sequences.
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_lock,
    input  logic                  m0_write,
    input  logic [3:0]            m0_wmask,
    input  logic [31:0]           m0_wdata,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rvalid,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_lock,
    input  logic                  m1_write,
    input  logic [3:0]            m1_wmask,
    input  logic [31:0]           m1_wdata,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rvalid,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    localparam lock_cnt_t MAX_CNT = lock_cnt_t'(MAX_LOCK);

    arb_state_t state;
    arb_state_t state_next;
    lock_cnt_t  cnt;
    lock_cnt_t  cnt_next;
    lock_cnt_t  cnt_inc;
    logic       force_pend;
    logic       force_pend_next;
    logic       force_sel;
    logic       force_sel_next;

    logic       req0_m;
    logic       req1_m;
    logic       gnt0;
    logic       gnt1;

    logic       rd_vld;
    logic       rd_own;

    arb_rr2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .clk       (clk),
        .rstn      (rstn),
        .req0      (req0_m),
        .req1      (req1_m),
        .force_en  (force_pend),
        .force_sel (force_sel),
        .gnt0      (gnt0),
        .gnt1      (gnt1)
    );

    // Lock FSM state register, lock counter and the pending forced hand-over.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            force_pend <= 1'b0;
            force_sel  <= M0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            force_pend <= force_pend_next;
            force_sel  <= force_sel_next;
        end
    end

    // Next-state logic: take the lock, hold it, or drop it (voluntarily or at the cap).
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        force_pend_next = 1'b0;
        force_sel_next  = force_sel;
        cnt_inc         = sat_inc(cnt);
        case (state)
            ARB_IDLE: begin
                cnt_next = '0;
                if (!force_pend && ((gnt0 && m0_lock) || (gnt1 && m1_lock))) begin
                    if (MAX_CNT <= lock_cnt_t'(1)) begin
                        force_pend_next = 1'b1;
                        force_sel_next  = gnt0 ? M1 : M0;
                    end else begin
                        state_next = gnt0 ? ARB_LOCK0 : ARB_LOCK1;
                        cnt_next   = lock_cnt_t'(1);
                    end
                end
            end
            ARB_LOCK0: begin
                if (!m0_lock) begin
                    state_next = ARB_IDLE;
                    cnt_next   = '0;
                end else if (cnt_inc >= MAX_CNT) begin
                    state_next      = ARB_IDLE;
                    cnt_next        = '0;
                    force_pend_next = 1'b1;
                    force_sel_next  = M1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ARB_LOCK1: begin
                if (!m1_lock) begin
                    state_next = ARB_IDLE;
                    cnt_next   = '0;
                end else if (cnt_inc >= MAX_CNT) begin
                    state_next      = ARB_IDLE;
                    cnt_next        = '0;
                    force_pend_next = 1'b1;
                    force_sel_next  = M0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = ARB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: while locked, the non-owner's request is hidden from the picker.
    always_comb begin
        req0_m = 1'b0;
        req1_m = 1'b0;
        case (state)
            ARB_IDLE: begin
                req0_m = m0_valid;
                req1_m = m1_valid;
            end
            ARB_LOCK0: begin
                req0_m = m0_valid;
            end
            ARB_LOCK1: begin
                req1_m = m1_valid;
            end
            default: begin
                req0_m = 1'b0;
                req1_m = 1'b0;
            end
        endcase
    end

    assign m0_ready = gnt0;
    assign m1_ready = gnt1;

    // Steer the granted master onto the memory port; idle bus drives all zeros.
    always_comb begin
        mem_valid = gnt0 | gnt1;
        mem_write = 1'b0;
        mem_wmask = '0;
        mem_wdata = '0;
        mem_addr  = '0;
        if (gnt0) begin
            mem_write = m0_write;
            mem_wmask = m0_wmask;
            mem_wdata = m0_wdata;
            mem_addr  = m0_addr;
        end else if (gnt1) begin
            mem_write = m1_write;
            mem_wmask = m1_wmask;
            mem_wdata = m1_wdata;
            mem_addr  = m1_addr;
        end
    end

    // Track which master's read is in flight so its rvalid rises next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld <= 1'b0;
            rd_own <= M0;
        end else begin
            rd_vld <= (gnt0 && !m0_write) || (gnt1 && !m1_write);
            rd_own <= gnt1 ? M1 : M0;
        end
    end

    assign m0_rvalid = rd_vld && (rd_own == M0);
    assign m1_rvalid = rd_vld && (rd_own == M1);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: a round-robin instance (a) and a
// fixed-priority instance (b), both with MAX_LOCK=4, share the stimulus.
module tb_mem_arbiter2;

    logic clk = 1'b0;
    logic rstn;

    logic        m0_valid, m0_lock, m0_write;
    logic [3:0]  m0_wmask;
    logic [31:0] m0_wdata, m0_addr;
    logic        m1_valid, m1_lock, m1_write;
    logic [3:0]  m1_wmask;
    logic [31:0] m1_wdata, m1_addr;

    logic        a_m0_ready, a_m0_rvalid, a_m1_ready, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_mem_valid, a_mem_write;
    logic [3:0]  a_mem_wmask;
    logic [31:0] a_mem_wdata, a_mem_addr, a_mem_rdata;

    logic        b_m0_ready, b_m0_rvalid, b_m1_ready, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_valid, b_mem_write;
    logic [3:0]  b_mem_wmask;
    logic [31:0] b_mem_wdata, b_mem_addr, b_mem_rdata;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       m0v;
        logic       m0l;
        logic       m1v;
        logic       m1l;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    mem_arbiter2 #(.ADDR_WIDTH(32), .FIXED_PRIO(0), .MAX_LOCK(4)) dut_a (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_lock(m0_lock), .m0_write(m0_write),
        .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
        .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
        .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_lock(m1_lock), .m1_write(m1_write),
        .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
        .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
        .mem_valid(a_mem_valid), .mem_write(a_mem_write), .mem_wmask(a_mem_wmask),
        .mem_wdata(a_mem_wdata), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter2 #(.ADDR_WIDTH(32), .FIXED_PRIO(1), .MAX_LOCK(4)) dut_b (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_lock(m0_lock), .m0_write(m0_write),
        .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
        .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
        .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_lock(m1_lock), .m1_write(m1_write),
        .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
        .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
        .mem_valid(b_mem_valid), .mem_write(b_mem_write), .mem_wmask(b_mem_wmask),
        .mem_wdata(b_mem_wdata), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata)
    );

    // Behavioural single-port RAM behind instance a: 1-cycle read, byte-masked write.
    always @(posedge clk) begin
        if (a_mem_valid) begin
            if (a_mem_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (a_mem_wmask[i]) mem_a[a_mem_addr[7:2]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
                end
            end else begin
                a_mem_rdata <= mem_a[a_mem_addr[7:2]];
            end
        end
    end

    // Same RAM model behind instance b.
    always @(posedge clk) begin
        if (b_mem_valid) begin
            if (b_mem_write) begin
                for (int j = 0; j < 4; j++) begin
                    if (b_mem_wmask[j]) mem_b[b_mem_addr[7:2]][8*j +: 8] <= b_mem_wdata[8*j +: 8];
                end
            end else begin
                b_mem_rdata <= mem_b[b_mem_addr[7:2]];
            end
        end
    end

    function automatic vec_t mk(input logic m0v, input logic m0l, input logic m1v,
                                input logic m1l, input logic [1:0] ea, input logic [1:0] eb);
        vec_t v;
        v.m0v   = m0v;
        v.m0l   = m0l;
        v.m1v   = m1v;
        v.m1l   = m1l;
        v.exp_a = ea;
        v.exp_b = eb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        m0_valid = v.m0v;
        m0_lock  = v.m0l;
        m0_write = 1'b0;
        m0_addr  = 32'h100;
        m1_valid = v.m1v;
        m1_lock  = v.m1l;
        m1_write = 1'b0;
        m1_addr  = 32'h104;
        #1;
    endtask

    task automatic idleInputs();
        m0_valid = 1'b0; m0_lock = 1'b0; m0_write = 1'b0;
        m1_valid = 1'b0; m1_lock = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        logic [1:0]  prev_a;
        logic [1:0]  prev_b;
        logic [31:0] exp_addr;

        for (int k = 0; k < 64; k++) begin
            mem_a[k] = 32'h0;
            mem_b[k] = 32'h0;
        end
        mem_a[4] = 32'hDEADBEEF; mem_b[4] = 32'hDEADBEEF;
        mem_a[8] = 32'hCAFEF00D; mem_b[8] = 32'hCAFEF00D;
        mem_a[9] = 32'h01020304; mem_b[9] = 32'h01020304;

        vecs[0]  = mk(1, 0, 1, 0, 2'b01, 2'b01);
        vecs[1]  = mk(1, 0, 1, 0, 2'b10, 2'b01);
        vecs[2]  = mk(1, 0, 1, 0, 2'b01, 2'b01);
        vecs[3]  = mk(1, 0, 1, 0, 2'b10, 2'b01);
        vecs[4]  = mk(0, 0, 0, 0, 2'b00, 2'b00);
        vecs[5]  = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[6]  = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[7]  = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[8]  = mk(1, 0, 1, 0, 2'b01, 2'b01);
        vecs[9]  = mk(0, 0, 1, 0, 2'b10, 2'b10);
        vecs[10] = mk(0, 0, 0, 0, 2'b00, 2'b00);
        vecs[11] = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[12] = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[13] = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[14] = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[15] = mk(1, 1, 1, 0, 2'b10, 2'b10);
        vecs[16] = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[17] = mk(1, 1, 1, 0, 2'b01, 2'b01);
        vecs[18] = mk(0, 1, 1, 0, 2'b00, 2'b00);
        vecs[19] = mk(0, 0, 1, 0, 2'b00, 2'b00);
        vecs[20] = mk(0, 0, 1, 0, 2'b10, 2'b10);
        vecs[21] = mk(0, 0, 0, 0, 2'b00, 2'b00);

        rstn = 1'b0;
        idleInputs();
        m0_wmask = 4'hF; m0_wdata = 32'hA5A5A5A5; m0_addr = 32'h44;
        m1_wmask = 4'h0; m1_wdata = 32'h0;        m1_addr = 32'h48;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset mem_valid", 32'(a_mem_valid), 32'd0);
        checkOutput("reset mem_addr", a_mem_addr, 32'd0);
        checkOutput("reset m0_rvalid", 32'(a_m0_rvalid), 32'd0);
        checkOutput("reset m1_rvalid", 32'(a_m1_rvalid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single read by m0.
        @(negedge clk);
        m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h10;
        #1;
        checkOutput("t1 m0_ready", 32'(a_m0_ready), 32'd1);
        checkOutput("t1 m1_ready", 32'(a_m1_ready), 32'd0);
        checkOutput("t1 mem_addr", a_mem_addr, 32'h10);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("t1 m0_rvalid", 32'(a_m0_rvalid), 32'd1);
        checkOutput("t1 m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        checkOutput("t1 m1_rvalid", 32'(a_m1_rvalid), 32'd0);
        checkOutput("t1 m1_rdata", a_m1_rdata, 32'hDEADBEEF);

        // Masked write by m1 racing a read by m0.
        @(negedge clk);
        m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h24;
        m1_valid = 1'b1; m1_write = 1'b1; m1_addr = 32'h20;
        m1_wdata = 32'h11223344; m1_wmask = 4'b0011;
        #1;
        checkOutput("t3 a m1_ready", 32'(a_m1_ready), 32'd1);
        checkOutput("t3 a m0_ready", 32'(a_m0_ready), 32'd0);
        checkOutput("t3 mem_write", 32'(a_mem_write), 32'd1);
        checkOutput("t3 mem_wmask", 32'(a_mem_wmask), 32'h3);
        checkOutput("t3 mem_wdata", a_mem_wdata, 32'h11223344);
        checkOutput("t3 mem_addr", a_mem_addr, 32'h20);
        checkOutput("t3 b m0_ready", 32'(b_m0_ready), 32'd1);
        checkOutput("t3 b m1_ready", 32'(b_m1_ready), 32'd0);
        @(negedge clk);
        m1_valid = 1'b0; m1_write = 1'b0;
        #1;
        checkOutput("t3 c2 m0_ready", 32'(a_m0_ready), 32'd1);
        checkOutput("t3 c2 m0_rvalid", 32'(a_m0_rvalid), 32'd0);
        checkOutput("t3 c2 m1_rvalid", 32'(a_m1_rvalid), 32'd0);
        @(negedge clk);
        m0_addr = 32'h20;
        #1;
        checkOutput("t3 c3 m0_ready", 32'(a_m0_ready), 32'd1);
        checkOutput("t3 c3 m0_rvalid", 32'(a_m0_rvalid), 32'd1);
        checkOutput("t3 c3 m0_rdata", a_m0_rdata, 32'h01020304);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("t3 c4 m0_rvalid", 32'(a_m0_rvalid), 32'd1);
        checkOutput("t3 c4 m0_rdata", a_m0_rdata, 32'hCAFE3344);

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Table: contention, voluntary lock, forced release and relock.
        prev_a = 2'b00;
        prev_b = 2'b00;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            exp_addr = vecs[i].exp_a[0] ? 32'h100 : (vecs[i].exp_a[1] ? 32'h104 : 32'h0);
            checkOutput($sformatf("row%0d a ready", i), 32'({a_m1_ready, a_m0_ready}), 32'(vecs[i].exp_a));
            checkOutput($sformatf("row%0d b ready", i), 32'({b_m1_ready, b_m0_ready}), 32'(vecs[i].exp_b));
            checkOutput($sformatf("row%0d a mem_valid", i), 32'(a_mem_valid), 32'(|vecs[i].exp_a));
            checkOutput($sformatf("row%0d a mem_addr", i), a_mem_addr, exp_addr);
            checkOutput($sformatf("row%0d a rvalid", i), 32'({a_m1_rvalid, a_m0_rvalid}), 32'(prev_a));
            checkOutput($sformatf("row%0d b rvalid", i), 32'({b_m1_rvalid, b_m0_rvalid}), 32'(prev_b));
            prev_a = vecs[i].exp_a;
            prev_b = vecs[i].exp_b;
        end

        // Reset while m1 holds the lock with a read in flight.
        @(negedge clk);
        idleInputs();
        m1_valid = 1'b1; m1_lock = 1'b1; m1_addr = 32'h10;
        #1;
        checkOutput("t6 acquire m1_ready", 32'(a_m1_ready), 32'd1);
        @(negedge clk);
        m0_valid = 1'b1;
        #1;
        checkOutput("t6 locked m1_ready", 32'(a_m1_ready), 32'd1);
        checkOutput("t6 locked m0_ready", 32'(a_m0_ready), 32'd0);
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0;
        #1;
        checkOutput("t6 pre-reset m1_rvalid", 32'(a_m1_rvalid), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("t6 reset a m1_rvalid", 32'(a_m1_rvalid), 32'd0);
        checkOutput("t6 reset b m1_rvalid", 32'(b_m1_rvalid), 32'd0);
        @(negedge clk);
        idleInputs();
        rstn = 1'b1;
        @(negedge clk);
        m0_valid = 1'b1; m1_valid = 1'b1;
        #1;
        checkOutput("t6 first tie m0_ready", 32'(a_m0_ready), 32'd1);
        checkOutput("t6 first tie m1_ready", 32'(a_m1_ready), 32'd0);
        @(negedge clk);
        idleInputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Shares one single-port synchronous memory (1-cycle read latency, 32-bit words, byte write mask) between two requesters: m0 = Pipeline data/instruction port, m1 = secondary master (loader/DMA).
- Sits between the masters and the Memory32Sim-class RAM.
- Provides round-robin or fixed-priority arbitration, a valid/ready handshake per master, and a bounded bus lock for atomic read-modify-write sequences.

Parameters:
- ADDR_WIDTH, 32, byte-address width on all address ports.
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins when both request.
- MAX_LOCK, 16, maximum consecutive cycles one master may hold the lock (range 1..255).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- m0_valid  in  1  m0 request.
- m0_ready  out  1  m0 request accepted this cycle.
- m0_lock  in  1  m0 requests ownership beyond this transfer.
- m0_write  in  1  1 = write, 0 = read.
- m0_wmask  in  4  byte enables for writes.
- m0_wdata  in  32  write data.
- m0_addr  in  ADDR_WIDTH  byte address.
- m0_rdata  out  32  read data (broadcast of mem_rdata).
- m0_rvalid  out  1  m0_rdata valid for m0's read accepted the previous cycle.
- m1_valid, m1_ready, m1_lock, m1_write, m1_wmask, m1_wdata, m1_addr, m1_rdata, m1_rvalid: same widths and meaning for m1.
- mem_valid  out  1  memory access this cycle.
- mem_write  out  1  write strobe.
- mem_wmask  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_rdata  in  32  read data, returned one cycle after the read.

Behaviour:
- Grant is combinational within the cycle. At most one mX_ready is high. mX_ready=1 implies mX_valid=1.
- mem_valid = m0_ready | m1_ready. mem_write, wmask, wdata and addr are muxed from the granted master; all zero when nothing is granted.
- State machine: IDLE, LOCK0, LOCK1.
- IDLE arbitration:
  - Only one master valid: that master is granted.
  - Both valid, FIXED_PRIO=1: m0 wins.
  - Both valid, FIXED_PRIO=0: the master not granted last wins. The last_grant register resets to m1, so m0 wins the first tie.
- IDLE -> LOCKx when mX is granted with mX_lock=1. The lock counter loads 1.
- LOCKx:
  - Only mX can be granted; the other master's ready is held 0 even if mX is idle.
  - Each cycle in LOCKx increments the counter.
  - Exit to IDLE when mX is granted with mX_lock=0 (that transfer still completes), when mX_lock is low while mX is not requesting, or when the counter reaches MAX_LOCK.
- Forced release at MAX_LOCK:
  - The next cycle is in IDLE.
  - If the other master is valid, it is granted regardless of FIXED_PRIO, exactly once.
  - A lock request in the same cycle as a forced release is ignored for that grant.
- Read return:
  - rd_owner register records {granted master, read} each cycle.
  - mX_rvalid = 1 exactly one cycle after mX's accepted read. It is never raised for writes.
  - Both rdata outputs always equal mem_rdata.
- Back-to-back reads by alternating masters: each rvalid appears in the correct following cycle with no gap.
- Reset (async, any time, including mid-lock or with a read outstanding):
  - state=IDLE, counter=0, last_grant=m1, rd_owner cleared.
  - All rvalid=0. The outstanding read is dropped.
- Width rules:
  - Counter width is 8 bits; it saturates, no wrap.
  - Addresses pass through unmodified. Masters guarantee word alignment for 32-bit access.

Decomposition:
- Shared package: state encoding (ARB_IDLE=0, ARB_LOCK0=1, ARB_LOCK1=2) and master-index constants (M0=0, M1=1).
- One natural sub-module, arb_rr2: a 2-way round-robin/fixed-priority picker with last_grant register and forced-priority override input.
- Lock FSM, counter and datapath mux live in mem_arbiter2.

Test Plan:
1. m0 reads addr 0x10 alone (mem holds 0xDEADBEEF) -> m0_ready=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
2. Both valid continuously, FIXED_PRIO=0 -> grants alternate m0,m1,m0,m1 starting with m0; with FIXED_PRIO=1 -> m0 every cycle, m1_ready never 1.
3. m1 writes 0x11223344 mask 4'b0011 to 0x20 while m0 reads 0x24 -> exactly one granted per cycle; m0 receives rvalid only after its own read; later read of 0x20 returns upper halfword unchanged, lower = 0x3344.
4. m0 locks (lock=1) for 3 transfers then lock=0, m1 valid throughout -> m1_ready=0 for those 4 cycles, m1 granted in cycle 5.
5. MAX_LOCK=4, m0 holds lock indefinitely, m1 valid -> after 4 locked cycles m1 granted once with FIXED_PRIO=1, then m0 may relock.
6. Assert rstn=0 in the cycle after an accepted m1 read during LOCK1 -> m1_rvalid=0 immediately; after release, IDLE and first tie goes to m0.
